// File: rtl/systolic_sequencer.sv
// rtl/systolic_sequencer.sv - Pass sequencer for an N x N output-stationary systolic array
// Drives clear, operand read, skew zero-fill and drain phases of one matrix-multiply pass.
module systolic_sequencer #(
    parameter int N  = 4,
    parameter int KW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic          abort,
    output logic          busy,
    output logic          pe_clear,
    output logic          rd_en,
    output logic [KW-1:0] rd_addr,
    output logic          operand_valid,
    output logic          zero_fill,
    output logic          done,
    output logic [15:0]   pass_cycles
);
    localparam int MAXLEN = ((2 ** KW) > (2 * N)) ? (2 ** KW) : (2 * N);
    localparam int PW     = $clog2(MAXLEN);
    // Drain covers read latency, input skew and propagation through the array.
    localparam logic [PW-1:0] DRAIN_LAST = PW'(2 * N - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [KW-1:0]   k_reg;
    logic [PW-1:0]   phase_cnt;
    logic [PW-1:0]   feed_last;
    logic [15:0]     cycle_cnt;

    assign feed_last = PW'(k_reg - KW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start && !abort) next_state = S_CLEAR;
            S_CLEAR: next_state = (k_reg == '0) ? S_DONE : S_FEED;
            S_FEED:  if (phase_cnt == feed_last) next_state = S_DRAIN;
            S_DRAIN: if (phase_cnt == DRAIN_LAST) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (abort && state != S_IDLE) next_state = S_IDLE;
    end

    always_comb begin
        busy      = (state != S_IDLE);
        pe_clear  = (state == S_CLEAR);
        rd_en     = (state == S_FEED);
        zero_fill = (state != S_FEED);
        done      = (state == S_DONE);
        rd_addr   = (state == S_FEED) ? phase_cnt[KW-1:0] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_reg         <= '0;
            phase_cnt     <= '0;
            cycle_cnt     <= '0;
            pass_cycles   <= '0;
            operand_valid <= 1'b0;
        end else begin
            operand_valid <= rd_en;
            if (state == S_IDLE && next_state == S_CLEAR) k_reg <= k_len;

            if (next_state != state)                     phase_cnt <= '0;
            else if (state == S_FEED || state == S_DRAIN) phase_cnt <= phase_cnt + PW'(1);
            else                                         phase_cnt <= '0;

            // Counter holds the busy cycles already completed; DONE adds its own cycle.
            if (state == S_IDLE && next_state == S_CLEAR)  cycle_cnt <= '0;
            else if (busy && cycle_cnt != 16'hFFFF)         cycle_cnt <= cycle_cnt + 16'd1;

            if (state == S_DONE && !abort)
                pass_cycles <= (cycle_cnt == 16'hFFFF) ? 16'hFFFF : cycle_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_systolic_sequencer.sv
// tb/tb_systolic_sequencer.sv - Self-checking bench for systolic_sequencer
// Table-driven passes, random passes against a timeline model, and hand-written corner sequences.
module tb_systolic_sequencer;
    localparam int N  = 4;
    localparam int KW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [KW-1:0] k_len;
    logic          abort;
    logic          busy;
    logic          pe_clear;
    logic          rd_en;
    logic [KW-1:0] rd_addr;
    logic          operand_valid;
    logic          zero_fill;
    logic          done;
    logic [15:0]   pass_cycles;

    systolic_sequencer #(.N(N), .KW(KW)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .abort(abort),
        .busy(busy), .pe_clear(pe_clear), .rd_en(rd_en), .rd_addr(rd_addr),
        .operand_valid(operand_valid), .zero_fill(zero_fill), .done(done),
        .pass_cycles(pass_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_pass = 0;

    typedef struct {
        int k;
        int abort_t;
        bit restart;
        int exp_pass;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] obs();
        return {busy, pe_clear, rd_en, operand_valid, zero_fill, done, rd_addr};
    endfunction

    // Timeline model: t=1 is the CLEAR cycle following the start edge.
    task automatic run_pass(input int k, input int abort_t, input bit restart, input int expp);
        int tdone;
        bit feed;
        bit aborted;
        logic [13:0] e;
        tdone   = (k == 0) ? 2 : k + 2 * N + 1;
        aborted = 1'b0;
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(k);
        for (int t = 1; t <= tdone; t++) begin
            @(negedge clk);
            start = restart && (t == 3);
            if (start) k_len = KW'(9);
            feed = (t >= 2) && (t <= k + 1);
            e = {1'b1, 1'(t == 1), feed, 1'((t >= 3) && (t <= k + 2)), ~feed,
                 1'(t == tdone), KW'(feed ? t - 2 : 0)};
            chk($sformatf("pass k=%0d t=%0d", k, t), 32'(obs()), 32'(e));
            if (t == abort_t) begin
                start = 1'b0;
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk($sformatf("abort k=%0d t=%0d", k, t), {28'd0, busy, rd_en, pe_clear, done}, 32'd0);
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) @(negedge clk);
        start = 1'b0;
        chk($sformatf("idle after k=%0d", k), 32'(busy), 32'd0);
        chk($sformatf("pass_cycles k=%0d", k), 32'(pass_cycles), 32'(expp));
        exp_pass = expp;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4,   0,  1'b0, 13};
        vecs[1] = '{0,   0,  1'b0, 2};
        vecs[2] = '{4,   3,  1'b0, 2};
        vecs[3] = '{4,   0,  1'b1, 13};
        vecs[4] = '{1,   0,  1'b0, 10};
        vecs[5] = '{255, 0,  1'b0, 264};
        vecs[6] = '{3,   1,  1'b0, 264};
        vecs[7] = '{2,   0,  1'b0, 11};
        vecs[8] = '{5,   14, 1'b0, 11};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        k_len = '0;
        @(negedge clk);
        chk("reset outputs", 32'(obs()), 32'(14'b00001000000000));
        chk("reset pass_cycles", 32'(pass_cycles), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_pass(vecs[i].k, vecs[i].abort_t, vecs[i].restart, vecs[i].exp_pass);

        // start together with abort in IDLE is dropped
        start = 1'b1;
        abort = 1'b1;
        k_len = KW'(7);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start+abort idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("start+abort still idle", 32'(busy), 32'd0);

        // start held high: passes run back to back
        start = 1'b1;
        k_len = KW'(2);
        for (int t = 1; t <= 24; t++) begin
            @(negedge clk);
            chk($sformatf("b2b pe_clear t=%0d", t), 32'(pe_clear), 32'((t == 1) || (t == 13)));
            chk($sformatf("b2b done t=%0d", t), 32'(done), 32'((t == 11) || (t == 23)));
            chk($sformatf("b2b busy t=%0d", t), 32'(busy), 32'((t != 12) && (t != 24)));
            if (t == 12 || t == 24) chk($sformatf("b2b pass_cycles t=%0d", t), 32'(pass_cycles), 32'd11);
        end
        start = 1'b0;
        exp_pass = 11;
        @(negedge clk);

        // asynchronous reset while draining
        start = 1'b1;
        k_len = KW'(4);
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("in drain", 32'({busy, zero_fill, rd_en}), 32'(3'b110));
        reset = 1'b1;
        #1;
        chk("async reset outputs", 32'(obs()), 32'(14'b00001000000000));
        chk("async reset pass_cycles", 32'(pass_cycles), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_pass = 0;
        run_pass(1, 0, 1'b0, 10);

        for (int i = 0; i < 20; i++) begin
            int k;
            int td;
            int ab;
            bit rs;
            k  = int'($urandom_range(0, 12));
            td = (k == 0) ? 2 : k + 2 * N + 1;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, td)) : 0;
            rs = 1'($urandom_range(0, 1));
            run_pass(k, ab, rs, (ab != 0) ? exp_pass : td);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/systolic_sequencer.md
SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 Parameter N, default 4: systolic array dimension (N x N processing elements).
REQ-002 Parameter KW, default 8: width of inner-dimension length and operand read address.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request one matrix-multiply pass; sampled only in IDLE.
REQ-006 k_len  input  KW  inner dimension (operand steps); captured on accepted start.
REQ-007 abort  input  1  synchronous cancel of the pass in progress.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 pe_clear  output  1  one-cycle clear pulse to all PE accumulators and operand registers.
REQ-010 rd_en  output  1  operand buffer read strobe (A row-vector and B column-vector banks).
REQ-011 rd_addr  output  KW  operand buffer read address (inner index k).
REQ-012 operand_valid  output  1  rd_en delayed one cycle; operand data present at skew-line inputs.
REQ-013 zero_fill  output  1  skew lines inject zeros instead of buffer data.
REQ-014 done  output  1  one-cycle pulse; all PE accumulators hold final results.
REQ-015 pass_cycles  output  16  cycle count of the last completed pass.

Function
REQ-016 States IDLE, CLEAR, FEED, DRAIN, DONE; encoding free.
REQ-017 IDLE -> CLEAR when start=1 and abort=0; k_len latched into k_reg at the same edge.
REQ-018 CLEAR lasts exactly 1 cycle; pe_clear=1 only in CLEAR.
REQ-019 CLEAR -> FEED when k_reg != 0; CLEAR -> DONE when k_reg == 0 (result all zeros, no reads).
REQ-020 FEED lasts exactly k_reg cycles; rd_en=1 throughout; rd_addr = 0,1,...,k_reg-1, incrementing by 1 per cycle.
REQ-021 rd_addr holds 0 outside FEED; no wrap possible since rd_addr < k_reg <= 2^KW-1.
REQ-022 operand_valid is a register of rd_en: high for exactly k_reg cycles, starting one cycle after the first rd_en.
REQ-023 DRAIN lasts exactly 2N-1 cycles (1 read latency + N-1 input skew + N-1 array propagation); zero_fill=1 in DRAIN.
REQ-024 zero_fill=1 also in IDLE, CLEAR, and DONE; zero_fill=0 only in FEED.
REQ-025 DRAIN -> DONE; DONE lasts 1 cycle with done=1; DONE -> IDLE unconditionally.
REQ-026 start asserted while busy=1 is ignored, not queued; k_reg unchanged.
REQ-027 abort=1 in any non-IDLE state -> IDLE at the next edge; no done pulse; pass_cycles unchanged; rd_en, pe_clear deasserted in the following cycle.
REQ-028 abort=1 together with start=1 in IDLE: start ignored, remain IDLE.
REQ-029 Internal cycle counter clears on entry to CLEAR and increments every busy cycle, saturating at 16'hFFFF.
REQ-030 On DONE, pass_cycles loads the counter value including the DONE cycle (= k_reg + 2N + 1 for k_reg != 0; 2 for k_reg == 0).
REQ-031 Phase length counters sized ceil(log2(max(2^KW, 2N))) bits; no arithmetic overflow across legal parameters.
REQ-032 done and pe_clear never asserted in the same cycle.

Reset
REQ-033 reset=1 forces IDLE immediately, independent of clk.
REQ-034 Reset values: busy=0, pe_clear=0, rd_en=0, rd_addr=0, operand_valid=0, zero_fill=1, done=0, pass_cycles=0, k_reg=0, counters=0.
REQ-035 reset asserted mid-pass discards the pass; first start after release begins a fresh pass from CLEAR.

Verification
REQ-036 N=4, k_len=4, start at cycle 0 -> pe_clear cycle 1; rd_en cycles 2-5 with rd_addr 0,1,2,3; operand_valid cycles 3-6; zero_fill cycles 6-12; done cycle 13; pass_cycles=13.
REQ-037 k_len=0, start -> pe_clear one cycle, done next cycle, no rd_en, pass_cycles=2.
REQ-038 k_len=4, abort in 2nd FEED cycle -> IDLE next cycle, rd_en low after, no done, pass_cycles keeps prior value.
REQ-039 start pulsed again during FEED with k_len=9 -> ignored; pass completes with 4 reads, done at cycle 13.
REQ-040 reset asserted during DRAIN -> all outputs at reset values without a clock edge; subsequent start with k_len=1 -> done 10 cycles after start, pass_cycles=10.
REQ-041 Back-to-back: start held high continuously with k_len=2 -> second CLEAR in the cycle after IDLE is re-entered, each pass pass_cycles=11.
